// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
// Holds the arbiter state encoding, the owner encoding and the tie-break
// helper used when both the fetch side and the load/store side request together.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_WORD_W      = 16;
    localparam int unsigned DEF_ADDR_W      = 16;
    localparam int unsigned DEF_MEM_LATENCY = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    // Decide who gets the memory when at least one side is requesting.
    // With rr_en clear a tie always goes to D; with rr_en set a tie goes to the
    // side that did not own the memory last time.
    function automatic arb_owner_e pick_owner(input logic       i_req,
                                              input logic       d_req,
                                              input arb_owner_e last_owner,
                                              input logic       rr_en);
        arb_owner_e winner;
        if (i_req && d_req) begin
            if (rr_en && (last_owner == OWN_D)) begin
                winner = OWN_I;
            end else begin
                winner = OWN_D;
            end
        end else if (d_req) begin
            winner = OWN_D;
        end else begin
            winner = OWN_I;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
// The arbiter uses the slave view; the CPU/memory environment uses the master view.
interface mem_port_arbiter_if #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ADDR_W = 16
);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [WORD_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic [WORD_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ack, d_rdata, d_ack,
               mem_read, mem_write, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack,
               mem_read, mem_write, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// mem_access_timer: counts the cycles of one memory access window.
// start loads the count with 1 (first access cycle); while run is high the
// count advances until it reaches MEM_LATENCY, where last is raised. The count
// never advances past MEM_LATENCY, so it cannot wrap in its narrow width.
module mem_access_timer #(
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic last
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = run && (cnt_q == CNT_W'(MEM_LATENCY));

    // Next count: reload on a new grant, otherwise step through the window.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CNT_W'(1);
        end else if (run && !last) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between the instruction
// fetch side (I) and the load/store side (D). One requester is granted at a
// time; address, direction and write data are latched at grant and held for the
// whole access window, and the owner gets a one-cycle ack after the window.
// Optional macro ARB_RR_EN: ties are broken toward the side that did not own the
// memory last; without it D always wins a tie. The owner register keeps its
// value between accesses, so it doubles as the last-owner record.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WORD_W      = DEF_WORD_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

`ifdef ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_e        state_q,   state_d;
    arb_owner_e        owner_q,   owner_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [WORD_W-1:0] wdata_q,   wdata_d;
    logic [WORD_W-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_W-1:0] d_rdata_q, d_rdata_d;

    logic timer_start;
    logic timer_run;
    logic access_last;

    assign timer_start = (state_q == ARB_IDLE) && (bus.i_req || bus.d_req);
    assign timer_run   = (state_q == ARB_ACCESS);

    mem_access_timer #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .run   (timer_run),
        .last  (access_last)
    );

    // Next-state logic: grant from IDLE only, capture read data on the last
    // access cycle, and always spend one RESP cycle before looking at requests
    // again so a still-high req cannot be granted twice.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    owner_d = pick_owner(bus.i_req, bus.d_req, owner_q, RR_EN);
                    if (owner_d == OWN_D) begin
                        addr_d  = bus.d_addr;
                        we_d    = bus.d_we;
                        wdata_d = bus.d_wdata;
                    end else begin
                        addr_d  = bus.i_addr;
                        we_d    = 1'b0;
                    end
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (access_last) begin
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            d_rdata_d = bus.mem_rdata;
                        end else begin
                            i_rdata_d = bus.mem_rdata;
                        end
                    end
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.mem_read  = (state_q == ARB_ACCESS) && !we_q;
    assign bus.mem_write = (state_q == ARB_ACCESS) &&  we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ack     = (state_q == ARB_RESP) && (owner_q == OWN_I);
    assign bus.d_ack     = (state_q == ARB_RESP) && (owner_q == OWN_D);
    assign bus.busy      = (state_q != ARB_IDLE);

endmodule
